// File: rtl/conv_run_sequencer.sv
// Host-side run sequencer for the conv accelerator: scan-loads data/weight SRAMs, starts the core,
// waits for completion, then streams both output SRAMs back as a valid/ready stream.
module conv_run_sequencer #(
   parameter int START_HOLD  = 2,
   parameter int READ_LAT    = 1,
   parameter int RUN_TIMEOUT = 1 << 20
) (
   input  logic         mem_clk,
   input  logic         clk_reset,
   input  logic         start_i,
   input  logic [8:0]   load_d_len_i,
   input  logic [8:0]   load_w_len_i,
   input  logic [8:0]   dump_len_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [511:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [511:0] out_data_o,
   output logic         out_bank_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o,
   output logic [7:0]   scan_addr_o,
   output logic         input_mem_scan_mode_o,
   output logic [1:0]   output_mem_scan_mode_o,
   output logic [511:0] data_mem_scan_in_o,
   output logic [511:0] weight_mem_scan_in_o,
   output logic         wen_o,
   input  logic         conv_completed_i,
   input  logic [511:0] output_mem1_scan_out_i,
   input  logic [511:0] output_mem2_scan_out_i
);

   localparam int TMAX_A = (START_HOLD > READ_LAT) ? START_HOLD : READ_LAT;
   localparam int TMAX   = (RUN_TIMEOUT > TMAX_A) ? RUN_TIMEOUT : TMAX_A;
   localparam int TW     = $clog2(TMAX + 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(START_HOLD - 1);
   localparam logic [TW-1:0] LAT_LAST  = TW'(READ_LAT - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(RUN_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD_D,
      S_LOAD_W,
      S_START,
      S_RUN,
      S_DUMP_ADDR,
      S_DUMP_WAIT,
      S_DUMP_OUT,
      S_FINISH
   } state_t;

   state_t        state_q, state_d;
   logic [8:0]    d_len_q, d_len_d;
   logic [8:0]    w_len_q, w_len_d;
   logic [8:0]    dump_len_q, dump_len_d;
   logic [8:0]    count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          bank_q, bank_d;
   logic [511:0]  out_data_q, out_data_d;
   logic          out_bank_q, out_bank_d;

   logic [8:0]    d_len_in, w_len_in, dump_len_in;

   function automatic logic [8:0] clamp_len(input logic [8:0] len);
      return (len > 9'd256) ? 9'd256 : len;
   endfunction

   assign d_len_in    = clamp_len(load_d_len_i);
   assign w_len_in    = clamp_len(load_w_len_i);
   assign dump_len_in = clamp_len(dump_len_i);

   assign busy_o     = (state_q != S_IDLE);
   assign out_data_o = out_data_q;
   assign out_bank_o = out_bank_q;

   always_comb begin
      state_d                = state_q;
      d_len_d                = d_len_q;
      w_len_d                = w_len_q;
      dump_len_d             = dump_len_q;
      count_d                = count_q;
      bank_d                 = bank_q;
      out_data_d             = out_data_q;
      out_bank_d             = out_bank_q;
      timer_d                = timer_q;
      in_ready_o             = 1'b0;
      out_valid_o            = 1'b0;
      done_o                 = 1'b0;
      err_o                  = 1'b0;
      scan_addr_o            = 8'd0;
      input_mem_scan_mode_o  = 1'b0;
      output_mem_scan_mode_o = 2'b00;
      data_mem_scan_in_o     = '0;
      weight_mem_scan_in_o   = '0;
      wen_o                  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               d_len_d    = d_len_in;
               w_len_d    = w_len_in;
               dump_len_d = dump_len_in;
               count_d    = 9'd0;
               bank_d     = 1'b0;
               if (d_len_in != 9'd0)
                  state_d = S_LOAD_D;
               else if (w_len_in != 9'd0)
                  state_d = S_LOAD_W;
               else
                  state_d = S_START;
            end
         end
         S_LOAD_D: begin
            in_ready_o            = 1'b1;
            input_mem_scan_mode_o = 1'b1;
            scan_addr_o           = count_q[7:0];
            if (in_valid_i) begin
               data_mem_scan_in_o = in_data_i;
               if (count_q == d_len_q - 9'd1) begin
                  count_d = 9'd0;
                  state_d = (w_len_q != 9'd0) ? S_LOAD_W : S_START;
               end else begin
                  count_d = count_q + 9'd1;
               end
            end
         end
         S_LOAD_W: begin
            in_ready_o            = 1'b1;
            input_mem_scan_mode_o = 1'b1;
            scan_addr_o           = count_q[7:0];
            if (in_valid_i) begin
               weight_mem_scan_in_o = in_data_i;
               if (count_q == w_len_q - 9'd1) begin
                  count_d = 9'd0;
                  state_d = S_START;
               end else begin
                  count_d = count_q + 9'd1;
               end
            end
         end
         S_START: begin
            // Held for several mem_clk cycles so the half-rate core clock is sure to see it.
            wen_o = 1'b1;
            if (timer_q == HOLD_LAST)
               state_d = S_RUN;
         end
         S_RUN: begin
            if (conv_completed_i) begin
               count_d = 9'd0;
               bank_d  = 1'b0;
               state_d = (dump_len_q != 9'd0) ? S_DUMP_ADDR : S_FINISH;
            end else if (timer_q == TO_LAST) begin
               err_o   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DUMP_ADDR: begin
            output_mem_scan_mode_o = 2'b10;
            scan_addr_o            = count_q[7:0];
            state_d                = S_DUMP_WAIT;
         end
         S_DUMP_WAIT: begin
            output_mem_scan_mode_o = 2'b10;
            scan_addr_o            = count_q[7:0];
            if (timer_q == LAT_LAST) begin
               out_data_d = bank_q ? output_mem2_scan_out_i : output_mem1_scan_out_i;
               out_bank_d = bank_q;
               state_d    = S_DUMP_OUT;
            end
         end
         S_DUMP_OUT: begin
            output_mem_scan_mode_o = 2'b10;
            scan_addr_o            = count_q[7:0];
            out_valid_o            = 1'b1;
            if (out_ready_i) begin
               if (count_q == dump_len_q - 9'd1) begin
                  count_d = 9'd0;
                  if (bank_q) begin
                     state_d = S_FINISH;
                  end else begin
                     bank_d  = 1'b1;
                     state_d = S_DUMP_ADDR;
                  end
               end else begin
                  count_d = count_q + 9'd1;
                  state_d = S_DUMP_ADDR;
               end
            end
         end
         S_FINISH: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // One shared timer serves the start hold, the run timeout and the read wait.
      if (state_d != state_q)
         timer_d = '0;
      else if (state_q == S_START || state_q == S_RUN || state_q == S_DUMP_WAIT)
         timer_d = timer_q + TW'(1);
   end

   always_ff @(posedge mem_clk or posedge clk_reset) begin
      if (clk_reset) begin
         state_q    <= S_IDLE;
         d_len_q    <= 9'd0;
         w_len_q    <= 9'd0;
         dump_len_q <= 9'd0;
         count_q    <= 9'd0;
         timer_q    <= '0;
         bank_q     <= 1'b0;
         out_data_q <= '0;
         out_bank_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         d_len_q    <= d_len_d;
         w_len_q    <= w_len_d;
         dump_len_q <= dump_len_d;
         count_q    <= count_d;
         timer_q    <= timer_d;
         bank_q     <= bank_d;
         out_data_q <= out_data_d;
         out_bank_q <= out_bank_d;
      end
   end

endmodule

// File: tb/tb_conv_run_sequencer.sv
// Randomized bench for conv_run_sequencer: a transaction-level model predicts scan writes and the
// dumped word order from the lengths; the environment models the output SRAMs and the core.
module tb_conv_run_sequencer;

   localparam int START_HOLD  = 2;
   localparam int READ_LAT    = 2;
   localparam int RUN_TIMEOUT = 100;

   logic         mem_clk = 1'b0;
   logic         clk_reset = 1'b1;
   logic         start_i = 1'b0;
   logic [8:0]   load_d_len_i = '0, load_w_len_i = '0, dump_len_i = '0;
   logic         in_valid_i = 1'b0, in_ready_o;
   logic [511:0] in_data_i = '0;
   logic         out_valid_o, out_ready_i = 1'b0;
   logic [511:0] out_data_o;
   logic         out_bank_o, busy_o, done_o, err_o;
   logic [7:0]   scan_addr_o;
   logic         input_mem_scan_mode_o;
   logic [1:0]   output_mem_scan_mode_o;
   logic [511:0] data_mem_scan_in_o, weight_mem_scan_in_o;
   logic         wen_o;
   logic         conv_completed_i = 1'b0;
   logic [511:0] m1_out = '0, m2_out = '0;

   always #5 mem_clk = ~mem_clk;

   conv_run_sequencer #(
      .START_HOLD(START_HOLD), .READ_LAT(READ_LAT), .RUN_TIMEOUT(RUN_TIMEOUT)
   ) dut (
      .mem_clk(mem_clk), .clk_reset(clk_reset), .start_i(start_i),
      .load_d_len_i(load_d_len_i), .load_w_len_i(load_w_len_i), .dump_len_i(dump_len_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .out_bank_o(out_bank_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .scan_addr_o(scan_addr_o), .input_mem_scan_mode_o(input_mem_scan_mode_o),
      .output_mem_scan_mode_o(output_mem_scan_mode_o),
      .data_mem_scan_in_o(data_mem_scan_in_o), .weight_mem_scan_in_o(weight_mem_scan_in_o),
      .wen_o(wen_o), .conv_completed_i(conv_completed_i),
      .output_mem1_scan_out_i(m1_out), .output_mem2_scan_out_i(m2_out)
   );

   // Output SRAMs with a two-cycle scan read latency.
   logic [511:0] m1 [256];
   logic [511:0] m2 [256];
   logic [7:0]   a_pipe = '0;
   always @(posedge mem_clk) begin
      a_pipe <= scan_addr_o;
      m1_out <= m1[a_pipe];
      m2_out <= m2[a_pipe];
   end

   typedef struct packed {
      logic         mode;
      logic [7:0]   addr;
      logic [511:0] dbus;
      logic [511:0] wbus;
   } beat_t;
   typedef struct packed {
      logic         bank;
      logic [511:0] data;
   } word_t;

   beat_t        exp_load[$], obs_load[$];
   word_t        exp_dump[$], obs_dump[$];
   logic [511:0] in_words[$];
   int checks = 0, failures = 0;
   int wen_cycles, done_cnt, err_cnt, ovalid_cnt, run_cycles, stall_bad, stall_cycles, mode_bad;
   bit op_done, done_with_cc, post_busy, post_any, rst_any;

   function automatic int clampi(input int x);
      return (x > 256) ? 256 : x;
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // Drives one complete operation and records what the DUT did; scenario tasks judge it.
   task automatic run_op(input int d, input int w, input int dp, input int gap, input int stall,
                         input int timeout, input int rst_dump, input int rnd_ready);
      int dc, wc, nc, total, beats, cyc, stall_left, dump_idx, compl_cnt;
      bit wen_seen, fin, prev_hold;
      word_t prev_w, cur_w;
      logic [511:0] wd;
      dc = clampi(d); wc = clampi(w); nc = clampi(dp); total = dc + wc;
      exp_load.delete(); obs_load.delete(); exp_dump.delete(); obs_dump.delete(); in_words.delete();
      for (int i = 0; i < dc; i++) begin
         wd = rand512(); in_words.push_back(wd);
         exp_load.push_back(beat_t'{mode: 1'b1, addr: 8'(i), dbus: wd, wbus: '0});
      end
      for (int i = 0; i < wc; i++) begin
         wd = rand512(); in_words.push_back(wd);
         exp_load.push_back(beat_t'{mode: 1'b1, addr: 8'(i), dbus: '0, wbus: wd});
      end
      for (int i = 0; i < nc; i++) begin m1[i] = rand512(); m2[i] = rand512(); end
      for (int i = 0; i < nc; i++) exp_dump.push_back(word_t'{bank: 1'b0, data: m1[i]});
      for (int i = 0; i < nc; i++) exp_dump.push_back(word_t'{bank: 1'b1, data: m2[i]});
      wen_cycles = 0; done_cnt = 0; err_cnt = 0; ovalid_cnt = 0; run_cycles = 0;
      stall_bad = 0; stall_cycles = 0; mode_bad = 0; done_with_cc = 0; rst_any = 1'b1;
      beats = 0; cyc = 0; dump_idx = 0; compl_cnt = 0; wen_seen = 0; fin = 0; prev_hold = 0;
      prev_w = '0; stall_left = stall ? 5 : 0;
      @(negedge mem_clk);
      load_d_len_i = 9'(d); load_w_len_i = 9'(w); dump_len_i = 9'(dp); start_i = 1'b1;
      while (!fin && cyc < 20000) begin
         @(negedge mem_clk);
         start_i = 1'b0;
         cyc++;
         case (gap)
            0:       in_valid_i = (beats < total);
            1:       in_valid_i = (beats < total) && (cyc % 2 == 0);
            default: in_valid_i = (beats < total) && ($urandom_range(0, 2) != 0);
         endcase
         in_data_i = (beats < total) ? in_words[beats] : rand512();
         if (stall && dump_idx == 1 && stall_left > 0) out_ready_i = 1'b0;
         else if (rnd_ready) out_ready_i = 1'($urandom_range(0, 1));
         else out_ready_i = 1'b1;
         conv_completed_i = !timeout && compl_cnt >= 3;
         #1;
         if (rst_dump && out_valid_o && dump_idx == 1) begin
            clk_reset = 1'b1;
            @(posedge mem_clk);
            #1;
            rst_any = |{in_ready_o, out_valid_o, out_data_o, out_bank_o, busy_o, done_o, err_o,
                        scan_addr_o, input_mem_scan_mode_o, output_mem_scan_mode_o,
                        data_mem_scan_in_o, weight_mem_scan_in_o, wen_o};
            @(negedge mem_clk);
            clk_reset = 1'b0;
            fin = 1;
         end else begin
            if (in_valid_i && in_ready_o) begin
               obs_load.push_back(beat_t'{mode: input_mem_scan_mode_o, addr: scan_addr_o,
                                          dbus: data_mem_scan_in_o, wbus: weight_mem_scan_in_o});
               beats++;
            end
            if (wen_o) begin wen_cycles++; wen_seen = 1; end
            if (wen_seen && !wen_o) compl_cnt++;
            if (wen_seen && !wen_o && busy_o) run_cycles++;
            cur_w = word_t'{bank: out_bank_o, data: out_data_o};
            if (prev_hold && (!out_valid_o || cur_w !== prev_w)) stall_bad++;
            prev_hold = out_valid_o && !out_ready_i;
            prev_w = cur_w;
            if (out_valid_o) begin
               ovalid_cnt++;
               if (output_mem_scan_mode_o !== 2'b10) mode_bad++;
               if (out_ready_i) begin
                  obs_dump.push_back(cur_w);
                  dump_idx++;
               end else begin
                  stall_cycles++;
                  if (stall && dump_idx == 1) stall_left--;
               end
            end
            if (done_o) begin done_cnt++; done_with_cc = conv_completed_i; end
            if (err_o) err_cnt++;
            if (done_o || err_o) fin = 1;
         end
      end
      op_done = fin;
      @(negedge mem_clk);
      in_valid_i = 1'b0; out_ready_i = 1'b0; conv_completed_i = 1'b0;
      #1;
      post_busy = busy_o;
      post_any = |{input_mem_scan_mode_o, output_mem_scan_mode_o, scan_addr_o, wen_o,
                   out_valid_o, in_ready_o};
      $display("op d=%0d w=%0d dump=%0d beats=%0d words=%0d wen=%0d done=%0d err=%0d cycles=%0d",
               d, w, dp, obs_load.size(), obs_dump.size(), wen_cycles, done_cnt, err_cnt, cyc);
   endtask

   task automatic test_reset();
      @(negedge mem_clk); @(negedge mem_clk); #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      checks++; if ({in_ready_o, out_valid_o, wen_o, done_o, err_o} !== 5'b0) begin
         failures++; $display("FAIL reset_ctrl: got %b want 00000", {in_ready_o, out_valid_o, wen_o, done_o, err_o}); end
      checks++; if ({scan_addr_o, input_mem_scan_mode_o, output_mem_scan_mode_o} !== 11'b0) begin
         failures++; $display("FAIL reset_scan: addr=%0d in_mode=%b out_mode=%b want 0", scan_addr_o, input_mem_scan_mode_o, output_mem_scan_mode_o); end
      checks++; if (|{out_data_o, out_bank_o, data_mem_scan_in_o, weight_mem_scan_in_o} !== 1'b0) begin
         failures++; $display("FAIL reset_data: data buses not zero, out_data[31:0]=%h", out_data_o[31:0]); end
      clk_reset = 1'b0;
      @(negedge mem_clk); #1;
      checks++; if ({busy_o, in_ready_o, out_valid_o, wen_o} !== 4'b0) begin
         failures++; $display("FAIL reset_release: got %b want 0000", {busy_o, in_ready_o, out_valid_o, wen_o}); end
   endtask

   task automatic test_load_no_dump();
      run_op(4, 2, 0, 0, 0, 0, 0, 0);
      checks++; if (!op_done) begin failures++; $display("FAIL load_finish: finished=%0d want 1", op_done); end
      checks++; if (obs_load.size() != exp_load.size()) begin
         failures++; $display("FAIL load_count: got %0d beats want %0d", obs_load.size(), exp_load.size()); end
      for (int i = 0; i < exp_load.size() && i < obs_load.size(); i++) begin
         checks++;
         if (obs_load[i] !== exp_load[i]) begin
            failures++;
            $display("FAIL load_beat[%0d]: mode=%b addr=%0d d=%h w=%h want mode=%b addr=%0d d=%h w=%h", i,
                     obs_load[i].mode, obs_load[i].addr, obs_load[i].dbus[31:0], obs_load[i].wbus[31:0],
                     exp_load[i].mode, exp_load[i].addr, exp_load[i].dbus[31:0], exp_load[i].wbus[31:0]);
         end
      end
      checks++; if (wen_cycles != START_HOLD) begin failures++; $display("FAIL load_wen: got %0d cycles want %0d", wen_cycles, START_HOLD); end
      checks++; if (done_cnt != 1 || ovalid_cnt != 0) begin
         failures++; $display("FAIL load_done: done=%0d out_valid=%0d want 1 and 0", done_cnt, ovalid_cnt); end
      checks++; if (post_busy !== 1'b0 || post_any !== 1'b0) begin
         failures++; $display("FAIL load_idle: busy=%b scan_any=%b want 0 0", post_busy, post_any); end
   endtask

   task automatic test_load_gaps();
      run_op(3, 0, 0, 1, 0, 0, 0, 0);
      checks++; if (obs_load.size() != 3) begin failures++; $display("FAIL gaps_count: got %0d want 3", obs_load.size()); end
      for (int i = 0; i < exp_load.size() && i < obs_load.size(); i++) begin
         checks++;
         if (obs_load[i] !== exp_load[i]) begin
            failures++;
            $display("FAIL gaps_beat[%0d]: addr=%0d d=%h want addr=%0d d=%h", i,
                     obs_load[i].addr, obs_load[i].dbus[31:0], exp_load[i].addr, exp_load[i].dbus[31:0]);
         end
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL gaps_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_dump_stall();
      run_op(0, 0, 3, 0, 1, 0, 0, 0);
      checks++; if (obs_dump.size() != 6) begin failures++; $display("FAIL stall_count: got %0d want 6", obs_dump.size()); end
      for (int i = 0; i < exp_dump.size() && i < obs_dump.size(); i++) begin
         checks++;
         if (obs_dump[i] !== exp_dump[i]) begin
            failures++;
            $display("FAIL stall_word[%0d]: bank=%b data=%h want bank=%b data=%h", i,
                     obs_dump[i].bank, obs_dump[i].data[31:0], exp_dump[i].bank, exp_dump[i].data[31:0]);
         end
      end
      checks++; if (stall_cycles != 5 || stall_bad != 0) begin
         failures++; $display("FAIL stall_hold: stalled=%0d unstable=%0d want 5 and 0", stall_cycles, stall_bad); end
      checks++; if (mode_bad != 0 || done_cnt != 1) begin
         failures++; $display("FAIL stall_mode: bad_mode=%0d done=%0d want 0 and 1", mode_bad, done_cnt); end
   endtask

   task automatic test_timeout();
      run_op(1, 0, 2, 0, 0, 1, 0, 0);
      checks++; if (err_cnt != 1 || done_cnt != 0) begin
         failures++; $display("FAIL timeout_err: err=%0d done=%0d want 1 and 0", err_cnt, done_cnt); end
      checks++; if (run_cycles != RUN_TIMEOUT) begin
         failures++; $display("FAIL timeout_cycles: got %0d run cycles want %0d", run_cycles, RUN_TIMEOUT); end
      checks++; if (ovalid_cnt != 0 || post_busy !== 1'b0) begin
         failures++; $display("FAIL timeout_idle: out_valid=%0d busy=%b want 0 0", ovalid_cnt, post_busy); end
   endtask

   task automatic test_zero();
      run_op(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (obs_load.size() != 0 || ovalid_cnt != 0) begin
         failures++; $display("FAIL zero_traffic: beats=%0d out_valid=%0d want 0 0", obs_load.size(), ovalid_cnt); end
      checks++; if (wen_cycles != START_HOLD) begin failures++; $display("FAIL zero_wen: got %0d want %0d", wen_cycles, START_HOLD); end
      checks++; if (done_cnt != 1 || !done_with_cc) begin
         failures++; $display("FAIL zero_done: done=%0d after_completed=%0d want 1 1", done_cnt, done_with_cc); end
   endtask

   task automatic test_reset_mid();
      run_op(1, 1, 3, 0, 1, 0, 1, 0);
      checks++; if (rst_any !== 1'b0) begin failures++; $display("FAIL midrst_outputs: any_nonzero=%b want 0", rst_any); end
      checks++; if (obs_dump.size() != 1 || obs_dump[0] !== exp_dump[0]) begin
         failures++; $display("FAIL midrst_prefix: words=%0d want 1 matching m1[0]", obs_dump.size()); end
      checks++; if (post_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", post_busy); end
      run_op(2, 1, 2, 0, 0, 0, 0, 0);
      checks++; if (obs_load.size() != exp_load.size() || obs_dump.size() != exp_dump.size()) begin
         failures++; $display("FAIL midrst_rerun_count: beats=%0d words=%0d want %0d %0d",
                              obs_load.size(), obs_dump.size(), exp_load.size(), exp_dump.size()); end
      for (int i = 0; i < exp_dump.size() && i < obs_dump.size(); i++) begin
         checks++;
         if (obs_dump[i] !== exp_dump[i]) begin
            failures++;
            $display("FAIL midrst_word[%0d]: bank=%b data=%h want bank=%b data=%h", i,
                     obs_dump[i].bank, obs_dump[i].data[31:0], exp_dump[i].bank, exp_dump[i].data[31:0]);
         end
      end
   endtask

   task automatic test_clamp();
      run_op(300, 0, 257, 0, 0, 0, 0, 0);
      checks++; if (obs_load.size() != 256 || obs_dump.size() != 512) begin
         failures++; $display("FAIL clamp_count: beats=%0d words=%0d want 256 512", obs_load.size(), obs_dump.size()); end
      for (int i = 0; i < exp_load.size() && i < obs_load.size(); i++) begin
         checks++;
         if (obs_load[i] !== exp_load[i]) begin
            failures++; $display("FAIL clamp_beat[%0d]: addr=%0d want %0d", i, obs_load[i].addr, exp_load[i].addr);
         end
      end
      for (int i = 0; i < exp_dump.size() && i < obs_dump.size(); i++) begin
         checks++;
         if (obs_dump[i] !== exp_dump[i]) begin
            failures++;
            $display("FAIL clamp_word[%0d]: bank=%b data=%h want bank=%b data=%h", i,
                     obs_dump[i].bank, obs_dump[i].data[31:0], exp_dump[i].bank, exp_dump[i].data[31:0]);
         end
      end
   endtask

   task automatic test_random();
      int d, w, dp;
      for (int n = 0; n < 5; n++) begin
         d = $urandom_range(0, 6); w = $urandom_range(0, 6); dp = $urandom_range(0, 5);
         run_op(d, w, dp, 2, 0, 0, 0, 1);
         checks++; if (!op_done || done_cnt != 1) begin
            failures++; $display("FAIL rand%0d_done: finished=%0d done=%0d want 1 1", n, op_done, done_cnt); end
         checks++; if (obs_load.size() != exp_load.size() || obs_dump.size() != exp_dump.size()) begin
            failures++; $display("FAIL rand%0d_count: beats=%0d words=%0d want %0d %0d", n,
                                 obs_load.size(), obs_dump.size(), exp_load.size(), exp_dump.size()); end
         for (int i = 0; i < exp_load.size() && i < obs_load.size(); i++) begin
            checks++;
            if (obs_load[i] !== exp_load[i]) begin
               failures++;
               $display("FAIL rand%0d_beat[%0d]: addr=%0d d=%h w=%h want addr=%0d d=%h w=%h", n, i,
                        obs_load[i].addr, obs_load[i].dbus[31:0], obs_load[i].wbus[31:0],
                        exp_load[i].addr, exp_load[i].dbus[31:0], exp_load[i].wbus[31:0]);
            end
         end
         for (int i = 0; i < exp_dump.size() && i < obs_dump.size(); i++) begin
            checks++;
            if (obs_dump[i] !== exp_dump[i]) begin
               failures++;
               $display("FAIL rand%0d_word[%0d]: bank=%b data=%h want bank=%b data=%h", n, i,
                        obs_dump[i].bank, obs_dump[i].data[31:0], exp_dump[i].bank, exp_dump[i].data[31:0]);
            end
         end
         checks++; if (stall_bad != 0 || mode_bad != 0) begin
            failures++; $display("FAIL rand%0d_hold: unstable=%0d bad_mode=%0d want 0 0", n, stall_bad, mode_bad); end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin m1[i] = '0; m2[i] = '0; end
      test_reset();
      test_load_no_dump();
      test_load_gaps();
      test_dump_stall();
      test_timeout();
      test_zero();
      test_reset_mid();
      test_clamp();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
